// File: rtl/pwm_gen_if.sv
// Sample handshake between the mixer and pwm_gen: the sender offers a duty
// code, and pwm_gen signals that its shadow register is free to take it.
interface pwm_gen_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] sample_i;
   logic             sample_valid_i;
   logic             sample_ready_o;

   modport master (output sample_i, sample_valid_i, input sample_ready_o);
   modport slave  (input sample_i, sample_valid_i, output sample_ready_o);
endinterface

// File: rtl/pwm_gen.sv
// Double-buffered PWM generator with edge- and centre-aligned modes and a
// clock prescaler. New duty codes only take effect at a period boundary.
module pwm_gen #(
   parameter int WIDTH = 8,
   parameter int DIV   = 1
) (
   input  logic     clk,
   input  logic     nrst,
   input  logic     en,
   input  logic     mode_i,
   pwm_gen_if.slave smp,
   output logic     period_o,
   output logic     underrun_o,
   output logic     PWM_o
);
   localparam int CW = WIDTH + 1;
   localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] MAX    = CW'((2 ** WIDTH) - 1);
   localparam logic [CW-1:0] LAST_E = CW'((2 ** WIDTH) - 2);
   localparam logic [CW-1:0] LAST_C = CW'(2 * ((2 ** WIDTH) - 1) - 1);
   localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

   logic [WIDTH-1:0] shadow, duty_q;
   logic             shadow_full, mode_q;
   logic [CW-1:0]    cnt, last, t;
   logic [DW-1:0]    div_cnt;
   logic             tick, wrap, hi, accept;

   assign smp.sample_ready_o = !shadow_full;
   assign accept = smp.sample_valid_i && !shadow_full;
   assign tick   = en && (div_cnt == DIV_LAST);
   assign last   = mode_q ? LAST_C : LAST_E;
   assign wrap   = tick && (cnt == last);
   // Centre mode folds the up/down sweep back onto a single ramp.
   assign t      = (cnt < MAX) ? cnt : (LAST_C - cnt);
   assign hi     = mode_q ? (t < {1'b0, duty_q}) : (cnt < {1'b0, duty_q});

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         shadow      <= '0;
         shadow_full <= 1'b0;
         duty_q      <= '0;
         mode_q      <= 1'b0;
         cnt         <= '0;
         div_cnt     <= '0;
         period_o    <= 1'b0;
         underrun_o  <= 1'b0;
         PWM_o       <= 1'b0;
      end else begin
         period_o   <= 1'b0;
         underrun_o <= 1'b0;
         // Accept and transfer are exclusive: accept needs the shadow empty.
         if (accept) begin
            shadow      <= smp.sample_i;
            shadow_full <= 1'b1;
         end
         if (!en) begin
            cnt     <= '0;
            div_cnt <= '0;
            PWM_o   <= 1'b0;
            mode_q  <= mode_i;
            if (shadow_full) begin
               duty_q      <= shadow;
               shadow_full <= 1'b0;
            end
         end else begin
            PWM_o <= hi;
            if (tick) begin
               div_cnt <= '0;
               cnt     <= wrap ? '0 : cnt + CW'(1);
            end else begin
               div_cnt <= div_cnt + DW'(1);
            end
            if (wrap) begin
               period_o <= 1'b1;
               mode_q   <= mode_i;
               if (shadow_full) begin
                  duty_q      <= shadow;
                  shadow_full <= 1'b0;
               end else begin
                  underrun_o <= 1'b1;
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_pwm_gen.sv
// Directed bench for pwm_gen: an 8-bit DIV=1 instance for edge/centre/buffer
// behaviour and an 8-bit DIV=4 instance for the prescaler and async reset.
module tb_pwm_gen;
   logic tb_clk = 1'b0;
   logic nrst;
   logic en, mode, en4, mode4;
   logic per, und, pwm, per4, und4, pwm4;
   int   n_chk = 0;
   int   n_pass = 0;
   // bit 0 pwm, 1 period, 2 underrun, 3 ready; index k = sample after posedge k
   logic [3:0] rec [0:1100];

   always #5 tb_clk = ~tb_clk;

   pwm_gen_if #(.WIDTH(8)) sif ();
   pwm_gen_if #(.WIDTH(8)) sif4 ();

   pwm_gen #(.WIDTH(8), .DIV(1)) dut (
      .clk(tb_clk), .nrst(nrst), .en(en), .mode_i(mode), .smp(sif.slave),
      .period_o(per), .underrun_o(und), .PWM_o(pwm));

   pwm_gen #(.WIDTH(8), .DIV(4)) dut4 (
      .clk(tb_clk), .nrst(nrst), .en(en4), .mode_i(mode4), .smp(sif4.slave),
      .period_o(per4), .underrun_o(und4), .PWM_o(pwm4));

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
   endtask

   function automatic int cnt1(input int b, input int lo, input int hi);
      int n = 0;
      for (int k = lo; k <= hi; k++) n += int'(rec[k][b]);
      return n;
   endfunction

   task automatic capture(input bit sel, input int n);
      for (int k = 1; k <= n; k++) begin
         @(negedge tb_clk);
         rec[k] = sel ? {sif4.sample_ready_o, und4, per4, pwm4}
                      : {sif.sample_ready_o, und, per, pwm};
      end
   endtask

   // Load a duty code with the block disabled; returns at a negedge with
   // the code in duty_q and cnt at 0.
   task automatic load(input bit sel, input logic [7:0] v);
      @(negedge tb_clk);
      if (sel) begin en4 = 0; sif4.sample_valid_i = 1; sif4.sample_i = v; end
      else     begin en  = 0; sif.sample_valid_i  = 1; sif.sample_i  = v; end
      @(negedge tb_clk);
      if (sel) sif4.sample_valid_i = 0; else sif.sample_valid_i = 0;
      @(negedge tb_clk);
   endtask

   initial begin
      nrst = 0;
      for (int i = 0; i < 2; i++) begin
         en = 1'($urandom); mode = 1'($urandom);
         sif.sample_valid_i = 1'($urandom); sif.sample_i = 8'($urandom);
         en4 = 1'($urandom); mode4 = 1'($urandom);
         sif4.sample_valid_i = 1'($urandom); sif4.sample_i = 8'($urandom);
         @(negedge tb_clk);
      end
      chk("rst_pwm", pwm, 0);
      chk("rst_ready", sif.sample_ready_o, 1);
      chk("rst_strobes", {per, und}, 0);
      nrst = 1; en = 0; mode = 0; sif.sample_valid_i = 0;
      en4 = 0; mode4 = 0; sif4.sample_valid_i = 0;
      @(negedge tb_clk);
      chk("rel_pwm", pwm, 0);
      chk("rel_ready", sif.sample_ready_o, 1);
      chk("rel_strobes", {per, und}, 0);

      // Edge mode, duty 127
      load(0, 8'd127);
      en = 1;
      capture(0, 510);
      chk("e_first_run", cnt1(0, 1, 127), 127);
      chk("e_low_run", cnt1(0, 128, 255), 0);
      chk("e_high_p2", cnt1(0, 256, 510), 127);
      chk("e_period_pos", {rec[255][1], rec[510][1]}, 3);
      chk("e_period_cnt", cnt1(1, 1, 510), 2);
      chk("e_underrun", {rec[255][2], rec[510][2]}, 3);
      chk("e_underrun_cnt", cnt1(2, 1, 510), 2);

      // Double buffering: 200 accepted at clock 50, then 30 offered while full
      @(negedge tb_clk); en = 0;
      @(negedge tb_clk); en = 1;
      for (int k = 1; k <= 510; k++) begin
         @(negedge tb_clk);
         rec[k] = {sif.sample_ready_o, und, per, pwm};
         if (k == 49) begin sif.sample_valid_i = 1; sif.sample_i = 8'd200; end
         if (k == 50) sif.sample_i = 8'd30;
         if (k == 60) sif.sample_valid_i = 0;
      end
      chk("db_cur_highs", cnt1(0, 1, 255), 127);
      chk("db_next_highs", cnt1(0, 256, 510), 200);
      chk("db_ready_low", 510 - cnt1(3, 1, 510), 205);
      chk("db_ready_edges", {rec[49][3], rec[50][3], rec[254][3], rec[255][3]}, 4'b1001);
      chk("db_no_underrun", int'(rec[255][2]), 0);

      // Extremes
      load(0, 8'd0);
      en = 1;
      capture(0, 765);
      chk("duty0_highs", cnt1(0, 1, 765), 0);
      load(0, 8'd255);
      en = 1;
      capture(0, 765);
      chk("duty255_highs", cnt1(0, 1, 765), 765);
      chk("duty255_periods", cnt1(1, 1, 765), 3);

      // Centre mode, duty 10
      mode = 1;
      load(0, 8'd10);
      en = 1;
      capture(0, 1020);
      chk("c_first_highs", cnt1(0, 1, 10), 10);
      chk("c_low_run", cnt1(0, 11, 500), 0);
      chk("c_wrap_run", cnt1(0, 501, 520), 20);
      chk("c_run_edges", {rec[500][0], rec[521][0]}, 0);
      chk("c_period_pos", {rec[510][1], rec[1020][1]}, 3);
      chk("c_period_cnt", cnt1(1, 1, 1020), 2);

      // Prescale DIV=4, duty 2, then asynchronous reset while PWM is high
      load(1, 8'd2);
      en4 = 1;
      capture(1, 1025);
      chk("p_first_highs", cnt1(0, 1, 8), 8);
      chk("p_low_run", cnt1(0, 9, 1020), 0);
      chk("p_period_pos", int'(rec[1020][1]), 1);
      chk("p_period_cnt", cnt1(1, 1, 1025), 1);
      chk("p_second_run", cnt1(0, 1021, 1025), 5);
      nrst = 0;
      #1;
      chk("p_rst_drop", pwm4, 0);
      @(negedge tb_clk);
      nrst = 1;
      capture(1, 1020);
      chk("p_after_rst_highs", cnt1(0, 1, 1020), 0);
      chk("p_after_rst_ready", int'(rec[1020][3]), 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/pwm_gen.md
# pwm_gen

Parametrised, double-buffered PWM generator, successor to the fixed 8-bit `pwm`. It converts a WIDTH-bit mixed sample into a pulse train on `PWM_o`, in either edge-aligned or centre-aligned mode, with an optional clock prescaler. Samples arrive over a valid/ready handshake into a shadow register and take effect only at a period boundary, so a duty change never produces a runt pulse. It sits between the mixer and the audio output pin.

## Interface
- WIDTH, default 8: sample width, at least 2. MAX = 2^WIDTH − 1.
- DIV, default 1: prescale ratio, at least 1. The counter advances once every DIV clocks.
- clk  in  1: system clock; all flops are rising-edge.
- nrst  in  1: asynchronous, active-low reset.
- en  in  1: run enable.
- mode_i  in  1: 0 = edge-aligned, 1 = centre-aligned.
- sample_i  in  WIDTH: duty code; 0 = always low, MAX = always high.
- sample_valid_i  in  1: `sample_i` is valid.
- sample_ready_o  out  1: the shadow register is empty.
- period_o  out  1: one-cycle strobe, one cycle after each wrap.
- underrun_o  out  1: one-cycle strobe when a wrap finds the shadow empty.
- PWM_o  out  1: PWM output, registered.

## Operation
- **Reset values.** All outputs are 0, except `sample_ready_o` = 1. Internal reset values: `duty_q` = 0, `shadow_full` = 0, `cnt` = 0, `div_cnt` = 0, `mode_q` = 0.
- **Accept.** A sample is accepted when `sample_valid_i` && `sample_ready_o` on a rising edge. It goes to `shadow`, and `shadow_full` is set to 1.
  - `sample_ready_o` = !`shadow_full`.
  - Valid while the shadow is full is ignored; the sender must hold it.
- **Prescaler.**
  - `tick` = `en` && (`div_cnt` == DIV−1).
  - When `en` = 1, `div_cnt` wraps 0..DIV−1.
  - With DIV = 1, `tick` = `en`.
- **Counter.** `cnt` is WIDTH+1 bits wide. LAST = MAX−1 in edge mode and 2·MAX−1 in centre mode.
  - On `tick`, `cnt` goes to 0 if it equals LAST, otherwise `cnt`+1.
  - `wrap` = `tick` && (`cnt` == LAST).
- **Compare.**
  - Edge mode: `hi` = (`cnt` < `duty_q`).
  - Centre mode: `t` = `cnt` when `cnt` < MAX, otherwise 2·MAX−1−`cnt`; `hi` = (`t` < `duty_q`).
  - Each edge: `PWM_o` <= `en` && `hi`, using the pre-edge register values.
- **Wrap.**
  - If `shadow_full`, then `duty_q` <= `shadow` and `shadow_full` <= 0.
  - Otherwise `duty_q` holds and `underrun_o` <= 1.
  - `period_o` <= 1 on every wrap.
  - `mode_q` <= `mode_i` on every wrap.
- **Disabled (`en` = 0).**
  - `cnt` and `div_cnt` are forced to 0; `PWM_o` <= 0; `period_o` and `underrun_o` stay 0.
  - A full shadow transfers to `duty_q` every cycle, and `mode_q` follows `mode_i`.
  - The first period after enable therefore uses the latest sample.
- **Simultaneous wrap and accept.** The old shadow moves to `duty_q`. The new sample is not accepted that edge, because ready was low. If the shadow was empty at the wrap, the sample is accepted into the shadow and underrun fires.
- **Reset mid-period.** Everything returns to reset values immediately; a pending shadow sample is lost.

## Timing
- **After enable.** On the first rising edge with `en` = 1, `cnt` = 0 is compared and `PWM_o` rises after that edge if `duty_q` > 0.
- **Edge-mode period.** The period is MAX·DIV clocks. `PWM_o` is high for `duty_q`·DIV clocks, starting at the period start.
- **Centre-mode period.** The period is 2·MAX·DIV clocks. `PWM_o` is high for 2·`duty_q`·DIV clocks, centred on the wrap.
- **Output latency.** `PWM_o` lags `cnt` by one clock.
- **Duty-change latency.** A sample accepted mid-period affects `PWM_o` from the first clock of the next period.
- **Strobes.** `period_o` and `underrun_o` are high exactly one clock, on the clock after the wrapping edge.
- **Ready.** `sample_ready_o` falls on the clock after acceptance. It rises on the clock after the wrap that consumes the shadow, or after the transfer when `en` = 0.

## Test plan
All scenarios use WIDTH = 8 (MAX = 255) unless stated.
- **Reset.** Hold `nrst` = 0 for 2 cycles with random inputs. Required: `PWM_o` = 0, `sample_ready_o` = 1, strobes 0. Release at negedge and check outputs are unchanged.
- **Edge mode, DIV = 1.** Load 127 with `en` = 0, then set `en` = 1. Required:
  - `PWM_o` high 127 clocks, then low 128.
  - `period_o` pulses every 255 clocks.
  - `underrun_o` pulses each wrap, since no new sample arrives.
- **Extremes.** Duty 0 gives `PWM_o` constantly 0 across 3 periods. Duty 255 gives `PWM_o` constantly 1 across 3 periods, including through wraps.
- **Double buffering.**
  - While 127 is active, send 200 at clock 50 of the period: the current period still has 127 highs, the next has 200.
  - `sample_ready_o` is low from the accept until the clock after the wrap.
  - A second valid 30 while full is not accepted.
- **Centre mode.** Set `mode_i` = 1 with duty 10. Required: period 510 clocks; `PWM_o` high for 20 consecutive clocks spanning the wrap (10 before, 10 after, plus the 1-clock lag); 490 clocks low.
- **Prescale and mid-period reset.** With DIV = 4, duty 2, edge mode: `PWM_o` high 8 clocks, period 1020 clocks. Assert `nrst` mid-period: `PWM_o` drops immediately and `duty_q` = 0 after release.
